// File: rtl/core_regfile_sb.sv
// core_regfile_sb: multi-port register file with write-to-read bypass and busy scoreboard
module core_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_RD-1:0]            rs_busy_o,
  input  logic [NUM_WR-1:0]            rd_we_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] rd_data_i,
  input  logic                         rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
  output logic [2**ADDR_WIDTH-1:0]     busy_vec_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  logic [DW-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]     busy, busy_nxt;
  logic [NUM_RD*DW-1:0] rd_val;
  logic [NUM_RD-1:0]    rb_val;
  assign busy_vec_o = busy;
  // Ascending port loops let the highest-index writer win on address collisions.
  always_comb begin
    busy_nxt = busy;
    rd_val = '0;
    rb_val = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (rd_we_i[w]) busy_nxt[rd_addr_i[w*AW +: AW]] = 1'b0;
    if (rsv_en_i) busy_nxt[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i*DW +: DW] = regs[rs_addr_i[i*AW +: AW]];
      for (int w = 0; w < NUM_WR; w++)
        if (BYPASS != 0 && rd_we_i[w] && rd_addr_i[w*AW +: AW] == rs_addr_i[i*AW +: AW])
          rd_val[i*DW +: DW] = rd_data_i[w*DW +: DW];
      if (ZERO_REG != 0 && rs_addr_i[i*AW +: AW] == '0) rd_val[i*DW +: DW] = '0;
      rb_val[i] = busy_nxt[rs_addr_i[i*AW +: AW]];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      busy      <= '0;
      rs_data_o <= '0;
      rs_busy_o <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (rd_we_i[w] && (ZERO_REG == 0 || rd_addr_i[w*AW +: AW] != '0))
          regs[rd_addr_i[w*AW +: AW]] <= rd_data_i[w*DW +: DW];
      busy      <= busy_nxt;
      rs_data_o <= rd_val;
      rs_busy_o <= rb_val;
    end
  end
endmodule

// File: tb/tb_core_regfile_sb.sv
// tb_core_regfile_sb: directed and randomized checks of core_regfile_sb (3 read, 2 write ports)
module tb_core_regfile_sb;
  localparam int DW = 32, AW = 5, NR = 3, NW = 2;
  logic clk = 0, rst = 0;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data;
  logic [NR-1:0]    rs_busy;
  logic [NW-1:0]    rd_we;
  logic [NW*AW-1:0] rd_addr;
  logic [NW*DW-1:0] rd_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [31:0]      busy_vec;
  int checks = 0, fails = 0;
  logic [DW-1:0] m_reg [32];
  logic [31:0]   m_busy;

  core_regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .rd_we_i(rd_we), .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .busy_vec_o(busy_vec));

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; rs_addr = '0; rd_we = '0; rd_addr = '0; rd_data = '0; rsv_en = 0; rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); idle();
    checks++; if (rs_data !== '0 || rs_busy !== '0 || busy_vec !== '0) begin
      fails++; $display("FAIL reset_state data=%h busy=%b vec=%h want 0", rs_data, rs_busy, busy_vec); end
    rd_we = 2'b01; rd_addr[0 +: AW] = 5; rd_data[0 +: DW] = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 5; step();
    idle(); rst = 1; rsv_en = 1; rsv_addr = 6; step();
    idle(); rs_addr[0 +: AW] = 5; step();
    checks++; if (rs_data[0 +: DW] !== 32'h0 || rs_busy[0] !== 1'b0) begin
      fails++; $display("FAIL reset_r5 data=%h busy=%b want 0/0", rs_data[0 +: DW], rs_busy[0]); end
    checks++; if (busy_vec !== 32'h0) begin
      fails++; $display("FAIL reset_vec got=%h want 0", busy_vec); end
  endtask

  task automatic test_bypass();
    idle(); rd_we = 2'b01; rd_addr[0 +: AW] = 3; rd_data[0 +: DW] = 32'h1234; rs_addr[0 +: AW] = 3; step();
    checks++; if (rs_data[0 +: DW] !== 32'h1234) begin
      fails++; $display("FAIL bypass_r3 got=%h want 00001234", rs_data[0 +: DW]); end
    idle(); rs_addr[AW +: AW] = 3; step();
    checks++; if (rs_data[DW +: DW] !== 32'h1234) begin
      fails++; $display("FAIL stored_r3 got=%h want 00001234", rs_data[DW +: DW]); end
  endtask

  task automatic test_zero_reg();
    idle(); rd_we = 2'b10; rd_addr[AW +: AW] = 0; rd_data[DW +: DW] = 32'hFFFFFFFF;
    rsv_en = 1; rsv_addr = 0; rs_addr[0 +: AW] = 0; step();
    checks++; if (rs_data[0 +: DW] !== 32'h0 || rs_busy[0] !== 1'b0) begin
      fails++; $display("FAIL zero_bypass data=%h busy=%b want 0/0", rs_data[0 +: DW], rs_busy[0]); end
    checks++; if (busy_vec[0] !== 1'b0) begin
      fails++; $display("FAIL zero_vec got=%b want 0", busy_vec[0]); end
    idle(); rs_addr[2*AW +: AW] = 0; step();
    checks++; if (rs_data[2*DW +: DW] !== 32'h0 || rs_busy[2] !== 1'b0) begin
      fails++; $display("FAIL zero_read data=%h busy=%b want 0/0", rs_data[2*DW +: DW], rs_busy[2]); end
  endtask

  task automatic test_write_priority();
    idle(); rd_we = 2'b11; rd_addr = {5'd7, 5'd7}; rd_data = {32'hB, 32'hA}; rs_addr[AW +: AW] = 7; step();
    checks++; if (rs_data[DW +: DW] !== 32'hB) begin
      fails++; $display("FAIL prio_bypass got=%h want 0000000b", rs_data[DW +: DW]); end
    idle(); rs_addr[0 +: AW] = 7; step();
    checks++; if (rs_data[0 +: DW] !== 32'hB) begin
      fails++; $display("FAIL prio_stored got=%h want 0000000b", rs_data[0 +: DW]); end
  endtask

  task automatic test_scoreboard();
    idle(); rsv_en = 1; rsv_addr = 9; step();
    checks++; if (busy_vec[9] !== 1'b1) begin
      fails++; $display("FAIL sb_reserve vec9=%b want 1", busy_vec[9]); end
    idle(); rs_addr[0 +: AW] = 9; step();
    checks++; if (rs_busy[0] !== 1'b1) begin
      fails++; $display("FAIL sb_read_busy got=%b want 1", rs_busy[0]); end
    idle(); rd_we = 2'b01; rd_addr[0 +: AW] = 9; rd_data[0 +: DW] = 32'h55; rs_addr[0 +: AW] = 9; step();
    checks++; if (busy_vec[9] !== 1'b0 || rs_busy[0] !== 1'b0 || rs_data[0 +: DW] !== 32'h55) begin
      fails++; $display("FAIL sb_release vec9=%b busy=%b data=%h want 0/0/55", busy_vec[9], rs_busy[0], rs_data[0 +: DW]); end
    idle(); rd_we = 2'b10; rd_addr[AW +: AW] = 9; rd_data[DW +: DW] = 32'h66; rsv_en = 1; rsv_addr = 9;
    rs_addr[0 +: AW] = 9; step();
    checks++; if (busy_vec[9] !== 1'b1 || rs_busy[0] !== 1'b1 || rs_data[0 +: DW] !== 32'h66) begin
      fails++; $display("FAIL sb_rsv_wins vec9=%b busy=%b data=%h want 1/1/66", busy_vec[9], rs_busy[0], rs_data[0 +: DW]); end
  endtask

  task automatic test_multi_read();
    idle(); rs_addr = {5'd9, 5'd7, 5'd3}; step();
    checks++; if (rs_data !== {32'h66, 32'hB, 32'h1234} || rs_busy !== 3'b100) begin
      fails++; $display("FAIL multi_distinct data=%h busy=%b want 00000066_0000000b_00001234/100", rs_data, rs_busy); end
    idle(); rs_addr = {5'd7, 5'd7, 5'd7}; step();
    checks++; if (rs_data !== {3{32'hB}} || rs_busy !== 3'b000) begin
      fails++; $display("FAIL multi_same data=%h busy=%b want 0000000b x3/000", rs_data, rs_busy); end
  endtask

  task automatic test_random();
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]    exp_busy;
    logic [AW-1:0]    a, wa;
    idle(); rst = 1; step();
    for (int n = 0; n < 32; n++) m_reg[n] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) rs_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
      for (int w = 0; w < NW; w++) begin
        rd_we[w] = $urandom_range(0, 1) == 1;
        rd_addr[w*AW +: AW] = AW'($urandom_range(0, 9));
        rd_data[w*DW +: DW] = $urandom;
      end
      rsv_en = $urandom_range(0, 1) == 1;
      rsv_addr = AW'($urandom_range(0, 9));
      exp_data = '0; exp_busy = '0;
      if (!rst) begin
        for (int i = 0; i < NR; i++) begin
          a = rs_addr[i*AW +: AW];
          exp_data[i*DW +: DW] = m_reg[a];
          exp_busy[i] = m_busy[a];
          for (int w = 0; w < NW; w++)
            if (rd_we[w] && rd_addr[w*AW +: AW] == a) begin
              exp_data[i*DW +: DW] = rd_data[w*DW +: DW]; exp_busy[i] = 0; end
          if (rsv_en && rsv_addr == a) exp_busy[i] = 1;
          if (a == 0) begin exp_data[i*DW +: DW] = '0; exp_busy[i] = 0; end
        end
        for (int w = 0; w < NW; w++) begin
          wa = rd_addr[w*AW +: AW];
          if (rd_we[w] && wa != 0) begin m_reg[wa] = rd_data[w*DW +: DW]; m_busy[wa] = 0; end
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
      end else begin
        for (int n = 0; n < 32; n++) m_reg[n] = '0;
        m_busy = '0;
      end
      step();
      checks++; if (rs_data !== exp_data || rs_busy !== exp_busy || busy_vec !== m_busy) begin
        fails++; $display("FAIL random cyc=%0d data=%h busy=%b vec=%h want %h/%b/%h",
                          cyc, rs_data, rs_busy, busy_vec, exp_data, exp_busy, m_busy); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_write_priority();
    test_scoreboard();
    test_multi_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
